imem_seq_ctrl: RTL and testbench
================================

// Module: imem_seq_ctrl
// PURPOSE
//  Sequencer for a PE instruction memory: accepts a streamed program, drives the
//  IMEM write port, then replays the program on the IMEM read port after a
//  programmable start delay. Sits between the host instruction stream and the
//  IMEM / PE array; replaces hardwired delay-line triggering of the program counter.
// PARAMETERS
//  INST_WIDTH    32  instruction word width
//  IM_ADDR_WIDTH 8   IMEM address width; depth = 2**IM_ADDR_WIDTH
//  START_DELAY   16  cycles spent in WAIT between last load beat and first read (>=1)
// PORTS
//  clk           in   1             single clock, all logic on posedge
//  rst_n         in   1             asynchronous, active-low reset
//  inst_in_v     in   1             instruction beat valid
//  inst_in       in   INST_WIDTH    instruction data
//  inst_in_last  in   1             qualifies final beat of program (with inst_in_v)
//  loop_cnt      in   8             program repetitions minus 1 (IMEM_SEQ_LOOP_EN only)
//  stall         in   1             PE back-pressure; freezes read sequencing
//  imem_we       out  1             IMEM write enable
//  imem_waddr    out  IM_ADDR_WIDTH IMEM write address
//  imem_wdata    out  INST_WIDTH    IMEM write data
//  imem_re       out  1             IMEM read enable (1-cycle read latency)
//  imem_raddr    out  IM_ADDR_WIDTH IMEM read address (program counter)
//  inst_out_v    out  1             imem_re delayed 1 cycle; aligns with IMEM data out
//  prog_len      out  IM_ADDR_WIDTH+1 loaded program length in words
//  busy          out  1             high in any state except IDLE
//  done          out  1             1-cycle pulse after final instruction issued
//  err_ovf       out  1             sticky: beat dropped (IMEM full / arrived in WAIT/RUN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, all outputs 0, counters 0, err_ovf cleared.
//  - FSM: IDLE -> LOAD -> WAIT -> RUN -> DONE -> IDLE.
//  - IDLE: inst_in_v=1 writes beat to addr 0 same cycle (imem_we comb. from valid),
//    wcnt<=1; goes to LOAD, or to WAIT directly if inst_in_last=1.
//  - LOAD: each valid beat: imem_we=1, imem_waddr=wcnt, wcnt++. Valid+last -> WAIT,
//    prog_len<=wcnt+1. Beat when wcnt==2**IM_ADDR_WIDTH: imem_we=0, err_ovf<=1;
//    if also last, prog_len<=depth and go to WAIT.
//  - WAIT: down-counter from START_DELAY-1; at 0 -> RUN with pc=0, iter=0.
//  - RUN: imem_re=!stall, imem_raddr=pc. When !stall: pc==prog_len-1 -> pc<=0,
//    iter++; else pc++. stall holds pc/iter; inst_out_v=0 one cycle later.
//    Final issue (pc==prog_len-1, iter==limit, !stall) -> DONE.
//  - DONE: done=1 one cycle, busy=1, -> IDLE. inst_out_v for last word asserts in DONE.
//  - inst_in_v in WAIT/RUN/DONE: ignored, err_ovf<=1. Program is not reloaded.
//  - prog_len holds after DONE; next load overwrites from addr 0.
//  - pc/wcnt never wrap beyond prog_len/depth; widths: wcnt,prog_len IM_ADDR_WIDTH+1.
//  - Reset mid-RUN: imem_re and inst_out_v drop immediately (async), no done pulse.
// CONFIGURATION
//  IMEM_SEQ_LOOP_EN defined: limit=loop_cnt, sampled on WAIT->RUN transition;
//    program replays loop_cnt+1 times back-to-back (no bubble at wrap).
//  Undefined: loop_cnt port absent, limit=0, program issued exactly once.
// TESTING
//  1 Load 4 beats (last on 4th), no stall, START_DELAY=16 -> waddr 0..3, prog_len=4,
//    first imem_re 16 cycles after last beat, raddr 0,1,2,3, done 1 cycle after raddr=3.
//  2 Single beat with last in IDLE -> prog_len=1, one imem_re at addr 0, done pulse.
//  3 stall=1 for 3 cycles at pc=2 of 4-word program -> raddr holds 2, imem_re=0,
//    inst_out_v gaps exactly 3 cycles, total issued words still 4.
//  4 IMEM_SEQ_LOOP_EN, loop_cnt=2, prog_len=3 -> raddr 0,1,2,0,1,2,0,1,2 contiguous.
//  5 Load 257 beats, ADDR_W=8 -> 256 writes, err_ovf=1, prog_len=256; beat in RUN -> no write.
//  6 rst_n low during RUN at pc=5 -> all outputs 0 same cycle; fresh load restarts at addr 0.

Source files
------------

// File: rtl/imem_seq_ctrl.sv
// -----------------------------------------------------------------------------
// imem_seq_ctrl
//   Instruction-memory sequencer for a PE array. It accepts a streamed program
//   and writes it into IMEM from address 0. It then waits a programmable
//   number of cycles. After that it replays the program on the IMEM read port
//   and pulses done once the final instruction has been issued.
//
//   Optional feature macro: IMEM_SEQ_LOOP_EN
//     defined   : loop_cnt port present; the program is replayed loop_cnt+1
//                 times back-to-back. loop_cnt is sampled on WAIT->RUN.
//     undefined : no loop_cnt port; the program is issued exactly once.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   inst_in_v/inst_in/_last     host instruction stream (last qualifies final beat)
//   loop_cnt                    repetitions minus 1 (IMEM_SEQ_LOOP_EN only)
//   stall                       PE back-pressure, freezes read sequencing
//   imem_we/waddr/wdata         IMEM write port (we combinational from valid)
//   imem_re/raddr               IMEM read port; raddr is the program counter
//   inst_out_v                  imem_re delayed one cycle (aligned to IMEM data)
//   prog_len                    loaded program length in words
//   busy / done                 not-IDLE / one-cycle completion pulse
//   err_ovf                     sticky: a beat was dropped
// -----------------------------------------------------------------------------
module imem_seq_ctrl #(
   parameter int INST_WIDTH    = 32,
   parameter int IM_ADDR_WIDTH = 8,
   parameter int START_DELAY   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     inst_in_v,
   input  logic [INST_WIDTH-1:0]    inst_in,
   input  logic                     inst_in_last,
`ifdef IMEM_SEQ_LOOP_EN
   input  logic [7:0]               loop_cnt,
`endif
   input  logic                     stall,
   output logic                     imem_we,
   output logic [IM_ADDR_WIDTH-1:0] imem_waddr,
   output logic [INST_WIDTH-1:0]    imem_wdata,
   output logic                     imem_re,
   output logic [IM_ADDR_WIDTH-1:0] imem_raddr,
   output logic                     inst_out_v,
   output logic [IM_ADDR_WIDTH:0]   prog_len,
   output logic                     busy,
   output logic                     done,
   output logic                     err_ovf
);

   localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam logic [DLY_W-1:0]       DLY_INIT = DLY_W'(START_DELAY - 1);
   // Full-memory word count: only the MSB of the extended counter is set.
   localparam logic [IM_ADDR_WIDTH:0] DEPTH_W  = {1'b1, {IM_ADDR_WIDTH{1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_RUN, S_DONE} state_e;

   state_e                   state_q;
   logic [IM_ADDR_WIDTH:0]   wcnt_q;
   logic [IM_ADDR_WIDTH:0]   prog_len_q;
   logic [IM_ADDR_WIDTH-1:0] pc_q;
   logic [7:0]               iter_q;
   logic [DLY_W-1:0]         dly_q;
   logic                     err_q;
   logic                     out_v_q;
   logic [7:0]               limit;

`ifdef IMEM_SEQ_LOOP_EN
   logic [7:0] limit_q;
   assign limit = limit_q;
`else
   assign limit = 8'd0;
`endif

   logic wr_ok;    // beat is accepted and written this cycle
   logic drop;     // beat arrives but cannot be written
   logic last_pc;  // pc addresses the final program word

   // IDLE always has room; LOAD is full once the counter reaches depth.
   assign wr_ok   = inst_in_v && ((state_q == S_IDLE) ||
                                  ((state_q == S_LOAD) && !wcnt_q[IM_ADDR_WIDTH]));
   assign drop    = inst_in_v && !wr_ok;
   assign last_pc = ({1'b0, pc_q} == (prog_len_q - 1'b1));

   assign imem_we    = wr_ok;
   assign imem_waddr = (wr_ok && state_q == S_LOAD) ? wcnt_q[IM_ADDR_WIDTH-1:0] : '0;
   assign imem_wdata = wr_ok ? inst_in : '0;
   assign imem_re    = (state_q == S_RUN) && !stall;
   assign imem_raddr = pc_q;
   assign inst_out_v = out_v_q;
   assign prog_len   = prog_len_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign err_ovf    = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wcnt_q     <= '0;
         prog_len_q <= '0;
         pc_q       <= '0;
         iter_q     <= '0;
         dly_q      <= '0;
         err_q      <= 1'b0;
         out_v_q    <= 1'b0;
`ifdef IMEM_SEQ_LOOP_EN
         limit_q    <= '0;
`endif
      end else begin
         out_v_q <= imem_re;
         if (drop) err_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (inst_in_v) begin
                  wcnt_q <= {{IM_ADDR_WIDTH{1'b0}}, 1'b1};
                  if (inst_in_last) begin
                     prog_len_q <= {{IM_ADDR_WIDTH{1'b0}}, 1'b1};
                     dly_q      <= DLY_INIT;
                     state_q    <= S_WAIT;
                  end else begin
                     state_q    <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (inst_in_v) begin
                  if (wr_ok) wcnt_q <= wcnt_q + 1'b1;
                  if (inst_in_last) begin
                     // A dropped final beat still closes the program at full depth.
                     prog_len_q <= wr_ok ? (wcnt_q + 1'b1) : DEPTH_W;
                     dly_q      <= DLY_INIT;
                     state_q    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (dly_q == '0) begin
                  pc_q    <= '0;
                  iter_q  <= '0;
`ifdef IMEM_SEQ_LOOP_EN
                  limit_q <= loop_cnt;
`endif
                  state_q <= S_RUN;
               end else begin
                  dly_q <= dly_q - 1'b1;
               end
            end
            S_RUN: begin
               if (!stall) begin
                  if (last_pc) begin
                     // Wrap with no bubble so loop iterations are contiguous.
                     pc_q <= '0;
                     if (iter_q == limit) state_q <= S_DONE;
                     else                 iter_q  <= iter_q + 1'b1;
                  end else begin
                     pc_q <= pc_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_seq_ctrl.sv
module tb_imem_seq_ctrl;
   localparam int IW = 32;
   localparam int AW = 8;
   localparam int SD = 16;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          inst_in_v = 1'b0;
   logic [IW-1:0] inst_in = '0;
   logic          inst_in_last = 1'b0;
   logic          stall = 1'b0;
`ifdef IMEM_SEQ_LOOP_EN
   logic [7:0]    loop_cnt = 8'd0;
`endif
   logic          imem_we, imem_re, inst_out_v, busy, done, err_ovf;
   logic [AW-1:0] imem_waddr, imem_raddr;
   logic [IW-1:0] imem_wdata;
   logic [AW:0]   prog_len;

   imem_seq_ctrl #(.INST_WIDTH(IW), .IM_ADDR_WIDTH(AW), .START_DELAY(SD)) dut (
      .clk(clk), .rst_n(rst_n), .inst_in_v(inst_in_v), .inst_in(inst_in),
      .inst_in_last(inst_in_last),
`ifdef IMEM_SEQ_LOOP_EN
      .loop_cnt(loop_cnt),
`endif
      .stall(stall), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .imem_re(imem_re), .imem_raddr(imem_raddr),
      .inst_out_v(inst_out_v), .prog_len(prog_len), .busy(busy), .done(done),
      .err_ovf(err_ovf));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard queues: expected writes and expected read addresses.
   logic [AW-1:0] wq_addr[$];
   logic [IW-1:0] wq_data[$];
   logic [AW-1:0] rq[$];

   int done_cnt = 0, done_cyc = -1;
   int re_cnt = 0, re_first = -1, re_last = -1;
   int ov_cnt = 0, ov_first = -1, ov_last = -1;
   int last_cyc = 0;

   // Monitor: sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      #2;
      if (imem_we) begin
         checks++;
         if (wq_addr.size() == 0) begin
            errors++; $display("FAIL unexpected_write addr=%0d cyc=%0d", imem_waddr, cyc);
         end else begin
            logic [AW-1:0] ea; logic [IW-1:0] ed;
            ea = wq_addr.pop_front(); ed = wq_data.pop_front();
            if (imem_waddr !== ea || imem_wdata !== ed) begin
               errors++;
               $display("FAIL write got=%0d/%h exp=%0d/%h", imem_waddr, imem_wdata, ea, ed);
            end
         end
      end
      if (imem_re) begin
         checks++;
         if (re_first < 0) re_first = cyc;
         re_last = cyc; re_cnt++;
         if (rq.size() == 0) begin
            errors++; $display("FAIL unexpected_read raddr=%0d cyc=%0d", imem_raddr, cyc);
         end else begin
            logic [AW-1:0] er;
            er = rq.pop_front();
            if (imem_raddr !== er) begin
               errors++; $display("FAIL read raddr got=%0d exp=%0d", imem_raddr, er);
            end
         end
      end
      if (inst_out_v) begin
         if (ov_first < 0) ov_first = cyc;
         ov_last = cyc; ov_cnt++;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
   end

   task automatic clr_stats();
      wq_addr.delete(); wq_data.delete(); rq.delete();
      re_cnt = 0; re_first = -1; re_last = -1;
      ov_cnt = 0; ov_first = -1; ov_last = -1; done_cyc = -1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; inst_in_v = 1'b0; inst_in_last = 1'b0; stall = 1'b0; inst_in = '0;
      repeat (2) @(negedge clk);
      clr_stats();
      rst_n = 1'b1;
   endtask

   task automatic load(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         inst_in_v = 1'b1; inst_in = IW'(base + i); inst_in_last = (i == n - 1);
         if (i < DEPTH) begin wq_addr.push_back(AW'(i)); wq_data.push_back(IW'(base + i)); end
         last_cyc = cyc;
      end
   endtask

   task automatic push_reads(input int n, input int reps);
      for (int r = 0; r < reps; r++)
         for (int a = 0; a < n; a++) rq.push_back(AW'(a));
   endtask

   // Runs until a done pulse. stall is high on cycles [sf,st]; a stray beat is
   // injected on cycle inj.
   task automatic run(input int budget, input int sf, input int st, input int inj);
      int n0; int k;
      n0 = done_cnt; k = 0;
      while (done_cnt == n0 && k < budget) begin
         @(negedge clk);
         inst_in_v = (cyc == inj); inst_in_last = 1'b0;
         stall = (cyc >= sf && cyc <= st);
         k++;
         #1;
         if (stall) begin
            checks++;
            if (imem_re !== 1'b0 || imem_raddr !== AW'(2)) begin
               errors++; $display("FAIL stall_hold re=%b raddr=%0d exp re=0 raddr=2", imem_re, imem_raddr);
            end
         end
         if (cyc == inj) begin
            checks++;
            if (imem_we !== 1'b0) begin
               errors++; $display("FAIL drop_no_write we=%b exp 0", imem_we);
            end
         end
      end
      inst_in_v = 1'b0; stall = 1'b0;
      checks++;
      if (done_cnt == n0) begin errors++; $display("FAIL run_timeout done never pulsed"); end
      repeat (2) @(negedge clk);
      checks++;
      if (rq.size() != 0 || wq_addr.size() != 0) begin
         errors++; $display("FAIL scoreboard_left reads=%0d writes=%0d exp 0", rq.size(), wq_addr.size());
      end
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      checks++;
      if ({imem_we, imem_waddr, imem_wdata, imem_re, imem_raddr, inst_out_v,
           prog_len, busy, done, err_ovf} !== '0) begin
         errors++; $display("FAIL reset_outputs got=%b exp all 0",
            {imem_we, imem_re, inst_out_v, busy, done, err_ovf});
      end
   endtask

   task automatic test_basic();
      do_reset();
      load(4, 32'h100); push_reads(4, 1);
      run(100, -10, -10, -10);
      checks++;
      if (prog_len !== 9'd4) begin errors++; $display("FAIL basic_prog_len got=%0d exp 4", prog_len); end
      checks++;
      if (re_first - last_cyc != SD + 1) begin
         errors++; $display("FAIL basic_start_delay got=%0d exp %0d", re_first - last_cyc, SD + 1);
      end
      checks++;
      if (done_cyc != re_last + 1) begin
         errors++; $display("FAIL basic_done_timing got=%0d exp %0d", done_cyc, re_last + 1);
      end
      checks++;
      if (ov_cnt != 4 || ov_last != done_cyc) begin
         errors++; $display("FAIL basic_out_v cnt=%0d last=%0d exp 4/%0d", ov_cnt, ov_last, done_cyc);
      end
      checks++;
      if (busy !== 1'b0 || err_ovf !== 1'b0) begin
         errors++; $display("FAIL basic_idle busy=%b err=%b exp 0/0", busy, err_ovf);
      end
   endtask

   task automatic test_single();
      do_reset();
      load(1, 32'hABCD); push_reads(1, 1);
      run(100, -10, -10, last_cyc + 5);  // stray beat during WAIT
      checks++;
      if (prog_len !== 9'd1 || re_cnt != 1) begin
         errors++; $display("FAIL single got len=%0d reads=%0d exp 1/1", prog_len, re_cnt);
      end
      checks++;
      if (err_ovf !== 1'b1) begin errors++; $display("FAIL wait_beat_err got=%b exp 1", err_ovf); end
   endtask

   task automatic test_stall();
      int s0;
      do_reset();
      load(4, 32'h200); push_reads(4, 1);
      s0 = last_cyc + SD + 1 + 2;   // cycle in which pc==2 is first presented
      run(100, s0, s0 + 2, -10);
      checks++;
      if (re_cnt != 4) begin errors++; $display("FAIL stall_issued got=%0d exp 4", re_cnt); end
      checks++;
      if ((ov_last - ov_first + 1) - ov_cnt != 3) begin
         errors++; $display("FAIL stall_gap got=%0d exp 3", (ov_last - ov_first + 1) - ov_cnt);
      end
   endtask

`ifdef IMEM_SEQ_LOOP_EN
   task automatic test_loop();
      do_reset();
      loop_cnt = 8'd2;
      load(3, 32'h300); push_reads(3, 3);
      run(200, -10, -10, -10);
      checks++;
      if (re_cnt != 9 || re_last - re_first != 8) begin
         errors++; $display("FAIL loop_contig cnt=%0d span=%0d exp 9/8", re_cnt, re_last - re_first);
      end
      loop_cnt = 8'd0;
   endtask
`endif

   task automatic test_ovf();
      do_reset();
      load(DEPTH + 1, 32'h1000); push_reads(DEPTH, 1);
      run(600, -10, -10, last_cyc + SD + 1 + 10);  // stray beat during RUN
      checks++;
      if (err_ovf !== 1'b1 || prog_len !== 9'd256) begin
         errors++; $display("FAIL ovf got err=%b len=%0d exp 1/256", err_ovf, prog_len);
      end
   endtask

   task automatic test_reset_mid_run();
      int tgt; int k;
      do_reset();
      load(8, 32'h400); push_reads(5, 1);
      tgt = last_cyc + SD + 1 + 5;   // pc==5 presented in this cycle
      k = 0;
      while (cyc < tgt && k < 200) begin
         @(negedge clk); inst_in_v = 1'b0; inst_in_last = 1'b0; k++;
      end
      rst_n = 1'b0; #1;
      checks++;
      if ({imem_re, inst_out_v, busy, done, imem_raddr} !== '0) begin
         errors++; $display("FAIL midrun_reset re=%b ov=%b busy=%b done=%b raddr=%0d exp 0",
            imem_re, inst_out_v, busy, done, imem_raddr);
      end
      checks++;
      if (rq.size() != 0) begin errors++; $display("FAIL midrun_reads left=%0d exp 0", rq.size()); end
      @(negedge clk); rst_n = 1'b1;
      load(2, 32'h500); push_reads(2, 1);
      run(100, -10, -10, -10);
      checks++;
      if (prog_len !== 9'd2) begin errors++; $display("FAIL reload_len got=%0d exp 2", prog_len); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_stall();
`ifdef IMEM_SEQ_LOOP_EN
      test_loop();
`endif
      test_ovf();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
